// File: rtl/wb_kbd_poller.sv
// wb_kbd_poller: Wishbone initiator that polls a keyboard peripheral and hands key codes to a consumer.
//   i_clk, i_rst                  : clock, asynchronous active-high reset
//   o_wb_adr/dat/sel/we/cyc/stb   : registered Wishbone initiator outputs (cyc == stb)
//   i_wb_rdt, i_wb_ack            : Wishbone read data and acknowledge
//   o_key, o_key_valid            : captured key code and its valid flag
//   i_key_ready                   : consumer handshake
//   o_err                         : one-cycle pulse on bus timeout
//   o_key_count                   : delivered key counter, wraps
module wb_kbd_poller #(
    parameter int POLL_DIV    = 1000,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [5:0]  o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic [7:0]  o_key,
    output logic        o_key_valid,
    input  logic        i_key_ready,
    output logic        o_err,
    output logic [15:0] o_key_count
);
    localparam int PW = $clog2(POLL_DIV);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_DIV - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD_FLAG, RD_DATA, CLR_FLAG, HOLD} state_t;

    state_t        r_state, w_state_n;
    logic [PW-1:0] r_poll;
    logic [WW-1:0] r_wait;
    logic [5:0]    r_adr, w_adr_n;
    logic [31:0]   r_dat, w_dat_n;
    logic [3:0]    r_sel, w_sel_n;
    logic          r_we, w_we_n, r_cyc, w_cyc_n, r_err, w_err_n;
    logic [7:0]    r_shadow, r_key;
    logic          r_key_valid;
    logic [15:0]   r_key_count;
    logic          w_tick, w_ack, w_tmo, w_ld, w_dlv;
    logic          w_unused;

    assign w_tick      = (r_poll == POLL_MAX);
    assign w_ack       = r_cyc & i_wb_ack;
    assign w_tmo       = r_cyc & ~i_wb_ack & (r_wait == WAIT_MAX);
    assign w_unused    = &{1'b0, i_wb_rdt[31:8]};
    assign o_wb_adr    = r_adr;
    assign o_wb_dat    = r_dat;
    assign o_wb_sel    = r_sel;
    assign o_wb_we     = r_we;
    assign o_wb_cyc    = r_cyc;
    assign o_wb_stb    = r_cyc;
    assign o_key       = r_key;
    assign o_key_valid = r_key_valid;
    assign o_err       = r_err;
    assign o_key_count = r_key_count;

    always_comb begin
        w_state_n = r_state;
        w_cyc_n   = r_cyc;
        w_adr_n   = r_adr;
        w_we_n    = r_we;
        w_dat_n   = r_dat;
        w_sel_n   = r_sel;
        w_err_n   = 1'b0;
        w_ld      = 1'b0;
        w_dlv     = 1'b0;
        case (r_state)
            IDLE: if (w_tick && !r_key_valid) begin
                w_state_n = RD_FLAG;
                w_cyc_n   = 1'b1;
                w_adr_n   = 6'h04;
                w_we_n    = 1'b0;
                w_dat_n   = '0;
                w_sel_n   = 4'hF;
            end
            RD_FLAG, RD_DATA, CLR_FLAG: begin
                if (!r_cyc) begin
                    // Launch this state's transaction after the one idle cycle that follows the previous ack.
                    w_cyc_n = 1'b1;
                    w_adr_n = (r_state == RD_DATA) ? 6'h00 : 6'h04;
                    w_we_n  = (r_state == CLR_FLAG);
                    w_dat_n = '0;
                    w_sel_n = 4'hF;
                end else if (w_ack) begin
                    w_cyc_n   = 1'b0;
                    w_ld      = (r_state == RD_DATA);
                    w_dlv     = (r_state == CLR_FLAG);
                    w_state_n = (r_state == RD_FLAG) ? (i_wb_rdt[0] ? RD_DATA : IDLE) :
                                (r_state == RD_DATA) ? CLR_FLAG : HOLD;
                end else if (w_tmo) begin
                    w_cyc_n   = 1'b0;
                    w_err_n   = 1'b1;
                    w_state_n = IDLE;
                end
            end
            HOLD: if (!r_key_valid) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_poll      <= '0;
            r_wait      <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_err       <= 1'b0;
            r_shadow    <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_key_count <= '0;
        end else begin
            r_state     <= w_state_n;
            r_poll      <= w_tick ? '0 : r_poll + 1'b1;
            // Wait counter restarts whenever a new strobe goes out.
            r_wait      <= (w_cyc_n && !r_cyc) ? '0 : r_cyc ? r_wait + 1'b1 : r_wait;
            r_adr       <= w_adr_n;
            r_dat       <= w_dat_n;
            r_sel       <= w_sel_n;
            r_we        <= w_we_n;
            r_cyc       <= w_cyc_n;
            r_err       <= w_err_n;
            if (w_ld) r_shadow <= i_wb_rdt[7:0];
            if (w_dlv) begin
                r_key       <= r_shadow;
                r_key_count <= r_key_count + 16'd1;
            end
            r_key_valid <= w_dlv | (r_key_valid & ~i_key_ready);
        end
    end
endmodule

// File: tb/tb_wb_kbd_poller.sv
// tb_wb_kbd_poller: randomized self-checking bench with a Wishbone keyboard slave model.
module tb_wb_kbd_poller;
    localparam int PD = 8;
    localparam int AT = 4;
    localparam logic [38:0] E_RF = {1'b0, 6'h04, 32'h0};
    localparam logic [38:0] E_RD = {1'b0, 6'h00, 32'h0};
    localparam logic [38:0] E_WF = {1'b1, 6'h04, 32'h0};

    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  o_wb_adr;
    logic [31:0] o_wb_dat, i_wb_rdt;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_wb_stb, o_key_valid, o_err;
    logic        i_key_ready = 1'b0;
    logic [7:0]  o_key;
    logic [15:0] o_key_count;

    int pass_cnt = 0, chk_cnt = 0;
    logic [7:0] reg0 = 8'h00;
    logic       reg1 = 1'b0;
    logic [7:0] kq[$];
    logic       s_ack = 1'b0;
    int         s_cnt = 0, s_dly = 0, dly_max = 0;
    bit         noack = 1'b0;
    int         rises = 0, hi = 0, errs = 0, vhi = 0, proto_bad = 0;
    bit         prev_cyc = 1'b0, prev_acked = 1'b0;
    logic [38:0] log_q[$];
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    wb_kbd_poller #(.POLL_DIV(PD), .ACK_TIMEOUT(AT)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt), .i_wb_ack(s_ack),
        .o_key(o_key), .o_key_valid(o_key_valid), .i_key_ready(i_key_ready),
        .o_err(o_err), .o_key_count(o_key_count)
    );

    assign i_wb_rdt = (o_wb_adr == 6'h00) ? {24'h0, reg0} : (o_wb_adr == 6'h04) ? {31'h0, reg1} : 32'h0;

    // Keyboard slave: acks s_dly cycles after seeing the strobe; clearing the flag pops the next queued key.
    always @(posedge clk) begin
        if (o_wb_cyc && o_wb_stb && !s_ack && !noack) begin
            if (s_cnt == s_dly) begin
                s_ack <= 1'b1;
                s_cnt <= 0;
                if (o_wb_we && o_wb_adr == 6'h04) begin
                    if (o_wb_dat[0]) reg1 = 1'b1;
                    else if (kq.size() > 0) begin reg0 = kq.pop_front(); reg1 = 1'b1; end
                    else reg1 = 1'b0;
                end
            end else s_cnt <= s_cnt + 1;
        end else begin
            s_ack <= 1'b0;
            if (!o_wb_cyc) begin
                s_cnt <= 0;
                s_dly <= int'($urandom_range(0, dly_max));
            end
        end
    end

    // Bus monitor: sampled values at the rising edge.
    always @(posedge clk) begin
        if (o_wb_cyc !== o_wb_stb) proto_bad++;
        if (prev_acked && o_wb_cyc) proto_bad++;
        if (o_wb_cyc && !prev_cyc) rises++;
        if (o_wb_cyc) hi++;
        if (o_wb_cyc && s_ack) log_q.push_back({o_wb_we, o_wb_adr, o_wb_we ? o_wb_dat : 32'h0});
        if (o_err) errs++;
        if (o_key_valid) vhi++;
        prev_acked = o_wb_cyc && s_ack;
        prev_cyc = o_wb_cyc;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(output int n);
        n = 0;
        while (o_wb_cyc !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (o_key_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        chk_cnt++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel} !== '0)
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h, want all 0", o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel);
        else pass_cnt++;
        chk_cnt++;
        if ({o_key, o_key_valid, o_err} !== '0)
            $display("FAIL reset_key: got key=%h valid=%b err=%b, want 0", o_key, o_key_valid, o_err);
        else pass_cnt++;
        chk_cnt++;
        if (o_key_count !== 16'h0) $display("FAIL reset_count: got %h want 0000", o_key_count);
        else pass_cnt++;
    endtask

    task automatic test_no_flag;
        int n;
        int bad;
        dly_max = 2;
        reg0 = 8'h55;
        reg1 = 1'b0;
        kq.delete();
        do_reset;
        wait_cyc(n);
        chk_cnt++;
        if (o_wb_cyc !== 1'b1) $display("FAIL noflag_start: no bus cycle within %0d cycles", n);
        else pass_cnt++;
        rises = 0;
        vhi = 0;
        log_q.delete();
        step(8 * PD);
        chk_cnt++;
        if (rises != 8) $display("FAIL noflag_rate: got %0d strobes in 64 cycles want 8", rises);
        else pass_cnt++;
        bad = 0;
        foreach (log_q[i]) if (log_q[i] !== E_RF) bad++;
        chk_cnt++;
        if (log_q.size() != 8 || bad != 0) $display("FAIL noflag_log: got %0d transfers (%0d not flag reads) want 8 flag reads", log_q.size(), bad);
        else pass_cnt++;
        chk_cnt++;
        if (vhi != 0) $display("FAIL noflag_valid: valid high %0d cycles want 0", vhi);
        else pass_cnt++;
    endtask

    task automatic test_key_delivery;
        int n;
        logic [7:0] code;
        dly_max = 0;
        i_key_ready = 1'b1;
        reg0 = 8'h1C;
        reg1 = 1'b1;
        kq.delete();
        do_reset;
        exp_count = 16'h0;
        wait_cyc(n);
        log_q.delete();
        vhi = 0;
        wait_valid(n);
        exp_count++;
        chk_cnt++;
        if (n != 8) $display("FAIL latency: valid %0d cycles after poll start want 8", n);
        else pass_cnt++;
        chk_cnt++;
        if (o_key !== 8'h1C) $display("FAIL deliver_key: got %h want 1c", o_key);
        else pass_cnt++;
        chk_cnt++;
        if (o_key_count !== exp_count) $display("FAIL deliver_count: got %h want %h", o_key_count, exp_count);
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if (o_key_valid !== 1'b0) $display("FAIL deliver_pulse: valid got %b want 0 one cycle later", o_key_valid);
        else pass_cnt++;
        step(2);
        chk_cnt++;
        if (log_q.size() != 3 || log_q[0] !== E_RF || log_q[1] !== E_RD || log_q[2] !== E_WF)
            $display("FAIL deliver_seq: got %0d transfers, want read 04, read 00, write 0 to 04", log_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (reg1 !== 1'b0 || vhi != 1) $display("FAIL deliver_flag: slave flag %b valid cycles %0d want 0 and 1", reg1, vhi);
        else pass_cnt++;
        dly_max = 2;
        repeat (4) begin
            code = 8'($urandom);
            reg0 = code;
            reg1 = 1'b1;
            wait_valid(n);
            exp_count++;
            chk_cnt++;
            if (o_key !== code || o_key_valid !== 1'b1) $display("FAIL rand_key: got %h valid %b want %h", o_key, o_key_valid, code);
            else pass_cnt++;
            chk_cnt++;
            if (o_key_count !== exp_count) $display("FAIL rand_count: got %h want %h", o_key_count, exp_count);
            else pass_cnt++;
            step(2);
        end
    endtask

    task automatic test_backpressure;
        int n;
        dly_max = 1;
        i_key_ready = 1'b0;
        reg0 = 8'h1C;
        reg1 = 1'b1;
        kq.delete();
        kq.push_back(8'h32);
        do_reset;
        wait_valid(n);
        chk_cnt++;
        if (o_key_valid !== 1'b1 || o_key !== 8'h1C) $display("FAIL bp_first: got key %h valid %b want 1c 1", o_key, o_key_valid);
        else pass_cnt++;
        rises = 0;
        step(5 * PD);
        chk_cnt++;
        if (rises != 0) $display("FAIL bp_nopoll: got %0d bus cycles while valid want 0", rises);
        else pass_cnt++;
        chk_cnt++;
        if (o_key !== 8'h1C || o_key_valid !== 1'b1 || reg1 !== 1'b1)
            $display("FAIL bp_hold: got key %h valid %b flag %b want 1c 1 1", o_key, o_key_valid, reg1);
        else pass_cnt++;
        i_key_ready = 1'b1;
        step(1);
        i_key_ready = 1'b0;
        chk_cnt++;
        if (o_key_valid !== 1'b0) $display("FAIL bp_consume: valid got %b want 0", o_key_valid);
        else pass_cnt++;
        i_key_ready = 1'b1;
        step(1);
        i_key_ready = 1'b0;
        wait_valid(n);
        chk_cnt++;
        if (o_key !== 8'h32 || o_key_count !== 16'd2) $display("FAIL bp_second: got key %h count %h want 32 0002", o_key, o_key_count);
        else pass_cnt++;
        i_key_ready = 1'b1;
        step(2);
    endtask

    task automatic test_timeout;
        int n;
        noack = 1'b1;
        i_key_ready = 1'b1;
        reg0 = 8'hA7;
        reg1 = 1'b1;
        kq.delete();
        do_reset;
        wait_cyc(n);
        hi = 0;
        errs = 0;
        n = 0;
        while (o_wb_cyc === 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk_cnt++;
        if (hi != AT) $display("FAIL tmo_len: cyc high %0d cycles want %0d", hi, AT);
        else pass_cnt++;
        step(3);
        chk_cnt++;
        if (errs != 1) $display("FAIL tmo_err: err high %0d cycles want 1", errs);
        else pass_cnt++;
        chk_cnt++;
        if (o_key_valid !== 1'b0 || o_key_count !== 16'h0 || o_key !== 8'h0)
            $display("FAIL tmo_state: got key %h valid %b count %h want unchanged zeros", o_key, o_key_valid, o_key_count);
        else pass_cnt++;
        noack = 1'b0;
        wait_cyc(n);
        chk_cnt++;
        if (o_wb_cyc !== 1'b1 || o_wb_adr !== 6'h04 || o_wb_we !== 1'b0)
            $display("FAIL tmo_retry: got cyc %b adr %h we %b want 1 04 0", o_wb_cyc, o_wb_adr, o_wb_we);
        else pass_cnt++;
        wait_valid(n);
        chk_cnt++;
        if (o_key !== 8'hA7 || o_key_valid !== 1'b1) $display("FAIL tmo_recover: got key %h valid %b want a7 1", o_key, o_key_valid);
        else pass_cnt++;
        step(2);
    endtask

    task automatic test_reset_mid;
        int n;
        logic [7:0] code;
        code = 8'($urandom);
        dly_max = 2;
        i_key_ready = 1'b1;
        reg0 = code;
        reg1 = 1'b1;
        kq.delete();
        do_reset;
        n = 0;
        while (!(o_wb_cyc === 1'b1 && o_wb_adr === 6'h00) && n < 100) begin @(negedge clk); n++; end
        chk_cnt++;
        if (o_wb_cyc !== 1'b1 || o_wb_adr !== 6'h00) $display("FAIL mid_find: data read not reached, cyc %b adr %h", o_wb_cyc, o_wb_adr);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        chk_cnt++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel, o_key, o_key_valid, o_err, o_key_count} !== '0)
            $display("FAIL mid_async: got cyc %b adr %h key %h count %h want all 0 at once", o_wb_cyc, o_wb_adr, o_key, o_key_count);
        else pass_cnt++;
        chk_cnt++;
        if (reg1 !== 1'b1) $display("FAIL mid_flag: slave flag got %b want 1", reg1);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(n);
        chk_cnt++;
        if (n != PD) $display("FAIL mid_first_poll: first strobe %0d cycles after release want %0d", n, PD);
        else pass_cnt++;
        wait_valid(n);
        chk_cnt++;
        if (o_key !== code || o_key_count !== 16'd1) $display("FAIL mid_deliver: got key %h count %h want %h 0001", o_key, o_key_count, code);
        else pass_cnt++;
        step(2);
    endtask

    task automatic test_count_wrap;
        int n;
        logic [7:0] code;
        code = 8'($urandom);
        dly_max = 1;
        i_key_ready = 1'b1;
        reg1 = 1'b0;
        kq.delete();
        do_reset;
        step(1);
        force dut.r_key_count = 16'hFFFF;
        step(1);
        release dut.r_key_count;
        step(1);
        chk_cnt++;
        if (o_key_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h want ffff", o_key_count);
        else pass_cnt++;
        reg0 = code;
        reg1 = 1'b1;
        wait_valid(n);
        chk_cnt++;
        if (o_key_count !== 16'h0000 || o_key !== code) $display("FAIL wrap_count: got count %h key %h want 0000 %h", o_key_count, o_key, code);
        else pass_cnt++;
        step(2);
    endtask

    task automatic test_protocol;
        chk_cnt++;
        if (proto_bad != 0) $display("FAIL protocol: %0d cyc/stb mismatches or strobes right after ack, want 0", proto_bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_no_flag;
        test_key_delivery;
        test_backpressure;
        test_timeout;
        test_reset_mid;
        test_count_wrap;
        test_protocol;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/wb_kbd_poller.md
WB_KBD_POLLER -- requirements
Module: wb_kbd_poller

Interface
REQ-001 SHALL have parameter POLL_DIV, default 1000: i_clk cycles between flag polls (min 2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: max cycles to wait for i_wb_ack per bus cycle.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 o_wb_adr  out  6  Wishbone byte address.
REQ-006 o_wb_dat  out  32  write data.
REQ-007 o_wb_sel  out  4  byte select.
REQ-008 o_wb_we  out  1  write enable.
REQ-009 o_wb_cyc  out  1  bus cycle.
REQ-010 o_wb_stb  out  1  strobe.
REQ-011 i_wb_rdt  in  32  read data from keyboard peripheral.
REQ-012 i_wb_ack  in  1  acknowledge.
REQ-013 o_key  out  8  captured key code.
REQ-014 o_key_valid  out  1  o_key holds an unconsumed code.
REQ-015 i_key_ready  in  1  consumer accepts o_key when high with o_key_valid.
REQ-016 o_err  out  1  one-cycle pulse on bus timeout.
REQ-017 o_key_count  out  16  number of keys delivered, wraps 0xFFFF->0.

Function
REQ-018 SHALL be a Wishbone initiator: keyboard code at offset 0x00 (reg0[7:0]), new-data flag at 0x04 (reg1[0]).
REQ-019 All Wishbone outputs SHALL be registered; o_wb_cyc and o_wb_stb SHALL always be equal.
REQ-020 Poll counter SHALL count 0..POLL_DIV-1 continuously and raise a tick when it wraps; a tick occurring while not in IDLE or while o_key_valid=1 SHALL be discarded.
REQ-021 FSM states: IDLE, RD_FLAG, RD_DATA, CLR_FLAG, HOLD.
REQ-022 IDLE->RD_FLAG on tick with o_key_valid=0; drive adr=0x04, we=0, sel=4'hF, cyc=stb=1.
REQ-023 RD_FLAG on ack: if i_wb_rdt[0]=0 -> IDLE; else -> RD_DATA (adr=0x00, we=0).
REQ-024 RD_DATA on ack: latch i_wb_rdt[7:0] into a shadow register -> CLR_FLAG (adr=0x04, we=1, dat=0, sel=4'hF).
REQ-025 CLR_FLAG on ack: o_key<=shadow, o_key_valid<=1, o_key_count+=1 -> HOLD.
REQ-026 On the edge where ack is sampled, cyc/stb SHALL be cleared; each new transaction SHALL start no earlier than one full cycle with cyc=0, so a slave that acks one cycle after cyc never sees a second strobe.
REQ-027 HOLD->IDLE when o_key_valid=0; o_key_valid SHALL clear on the cycle after i_key_ready=1 sampled with o_key_valid=1; o_key stable while valid.
REQ-028 i_key_ready while o_key_valid=0 SHALL have no effect.
REQ-029 Timeout: wait counter resets at each stb assertion; if ACK_TIMEOUT cycles pass without ack in any bus state, drop cyc/stb, pulse o_err one cycle, go IDLE; shadow, o_key, o_key_valid, o_key_count unchanged.
REQ-030 i_wb_ack while cyc=0 SHALL be ignored.
REQ-031 Latency tick->o_key_valid with ack one cycle after stb: three transactions of 2 cycles plus 1 idle between each, o_key_valid high 8 cycles after tick.

Reset
REQ-032 On i_rst (asynchronous): state IDLE, poll and wait counters 0, cyc=stb=we=0, adr=0, dat=0, sel=0, o_key=0, o_key_valid=0, o_err=0, o_key_count=0.
REQ-033 Reset mid-transaction SHALL drop cyc/stb immediately without completing the flag clear; first poll after release occurs POLL_DIV cycles later.

Verification
REQ-034 Flag=0: slave model reg1=0, POLL_DIV=8 -> exactly one read of 0x04 per 8 cycles, no other cycles, o_key_valid stays 0.
REQ-035 Key delivery: reg1=1, reg0=0x1C, i_key_ready=1 -> reads 0x04, 0x00, write 0 to 0x04; o_key=0x1C, o_key_valid pulses one cycle, o_key_count=1, reg1=0 afterwards.
REQ-036 Backpressure: i_key_ready=0, two keys queued (0x1C then 0x32) -> no poll while valid, o_key holds 0x1C; after ready, 0x32 delivered next poll.
REQ-037 Timeout: ACK_TIMEOUT=4, slave never acks -> cyc drops after 4 cycles, o_err one-cycle pulse, next poll retries 0x04.
REQ-038 Async reset asserted during RD_DATA -> cyc=0 same cycle, all outputs reset values, reg1 still 1 in slave, key delivered on first poll after release.
REQ-039 Count wrap: preload 0xFFFF deliveries (force) then one key -> o_key_count=0x0000.
